// File: rtl/mul_pkg.sv
// mul_pkg: shared width, counter width and FSM state encoding for the sequential multiplier
package mul_pkg;
  localparam int MUL_WIDTH = 24;
  localparam int MUL_CNT_W = $clog2(MUL_WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/add_24bit.sv
// add_24bit: WIDTH-bit adder with carry-out; used for the multiply accumulate and shareable with the ALU add path
module add_24bit #(
  parameter int WIDTH = 24
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);
  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b};
endmodule

// File: rtl/mul_seq_24bit.sv
// mul_seq_24bit: iterative shift-add multiplier, one product bit per clock, 25-cycle latency.
// Define MUL_SIGNED_EN for two's-complement operands (magnitude multiply, sign fix-up at the final load).
module mul_seq_24bit
  import mul_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [MUL_WIDTH-1:0] a,
  input  logic [MUL_WIDTH-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [MUL_WIDTH-1:0] product_lo,
  output logic [MUL_WIDTH-1:0] product_hi
);
  state_t                 r_state, w_next;
  logic [MUL_WIDTH-1:0]   r_mcand, r_mplr, r_acc;
  logic [MUL_CNT_W-1:0]   r_cnt;
  logic [MUL_WIDTH-1:0]   w_addend, w_sum, w_a_in, w_b_in;
  logic [2*MUL_WIDTH-1:0] w_raw, w_prod;
  logic                   w_cout, w_accept, w_last, w_run;

  assign w_run    = r_state == RUN;
  assign w_accept = start && !w_run;
  assign w_last   = r_cnt == MUL_CNT_W'(MUL_WIDTH - 1);
  assign w_addend = r_mplr[0] ? r_mcand : '0;
  assign busy     = w_run;
  assign done     = r_state == DONE;

  add_24bit #(.WIDTH(MUL_WIDTH)) u_add (
    .i_a    (r_acc),
    .i_b    (w_addend),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Product as it will stand after this cycle's shift; captured on the final iteration.
  assign w_raw = {w_cout, w_sum, r_mplr[MUL_WIDTH-1:1]};

`ifdef MUL_SIGNED_EN
  logic r_neg;
  assign w_a_in = a[MUL_WIDTH-1] ? -a : a;
  assign w_b_in = b[MUL_WIDTH-1] ? -b : b;
  assign w_prod = r_neg ? -w_raw : w_raw;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_neg <= 1'b0;
    else if (w_accept) r_neg <= a[MUL_WIDTH-1] ^ b[MUL_WIDTH-1];
  end
`else
  assign w_a_in = a;
  assign w_b_in = b;
  assign w_prod = w_raw;
`endif

  always_comb begin
    w_next = w_accept ? RUN : (w_run && !w_last) ? RUN : w_run ? DONE : IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand    <= '0;
      r_mplr     <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      product_lo <= '0;
      product_hi <= '0;
    end else begin
      if (w_accept) begin
        r_mcand <= w_a_in;
        r_mplr  <= w_b_in;
        r_acc   <= '0;
        r_cnt   <= '0;
      end else if (w_run) begin
        r_acc  <= {w_cout, w_sum[MUL_WIDTH-1:1]};
        r_mplr <= {w_sum[0], r_mplr[MUL_WIDTH-1:1]};
        r_cnt  <= r_cnt + MUL_CNT_W'(1);
      end
      if (w_run && w_last) {product_hi, product_lo} <= w_prod;
    end
  end
endmodule
